// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-framed, XOR-checksummed program image over a
// valid/ready byte stream, writes the payload into instruction memory and holds
// the core in reset until the image has been verified.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] StLenHi = 3'd0;
  localparam logic [2:0] StLenLo = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  localparam logic [15:0] MaxLen = 16'(MEM_BYTES);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;

  logic              accept;
  logic [15:0]       len_rx;
  logic [15:0]       count_inc;

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    s_ready    = (state_q == StLenHi) || (state_q == StLenLo) ||
                 (state_q == StLoad)  || (state_q == StCsum);
    done       = (state_q == StDone);
    error      = (state_q == StErr);
    core_reset = ~done;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_data   = mem_data_q;
  end

  assign accept    = s_valid & s_ready;
  assign len_rx    = {len_hi_q, s_data};
  assign count_inc = count_q + 16'd1;

  // Next-state logic for the frame parser and the registered write port.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    count_d    = count_q;
    csum_d     = csum_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      StLenHi: begin
        if (accept) begin
          len_hi_d = s_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_rx;
          // Oversize is rejected here so the address can never wrap in StLoad.
          if (len_rx > MaxLen)        state_d = StErr;
          else if (len_rx == 16'd0)   state_d = StCsum;
          else                        state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = count_q[ADDR_W-1:0];
          mem_data_d = s_data;
          csum_d     = csum_q ^ s_data;
          count_d    = count_inc;
          if (count_inc == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (accept) state_d = (s_data == csum_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (restart) begin
          state_d  = StLenHi;
          len_hi_d = 8'd0;
          len_d    = 16'd0;
          count_d  = 16'd0;
          csum_d   = 8'd0;
        end
      end
      default: state_d = StLenHi;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StLenHi;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      count_q    <= 16'd0;
      csum_q     <= 8'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are built from the image
// rules, the expected write trace and final status come from a frame-level model.
module tb_imem_boot_loader;

  localparam int unsigned MemBytes = 256;

  logic       clk;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       restart;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       core_reset;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] frame_q[$];
  int         exp_cyc[$];
  int         exp_addr[$];
  int         exp_data[$];
  int         obs_cyc[$];
  int         obs_addr[$];
  int         obs_data[$];
  int         last_acc_cyc;

  imem_boot_loader #(
    .ADDR_W   (8),
    .MEM_BYTES(MemBytes)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(int'(mem_data));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // Called just after a rising edge. Offers one byte, waits for acceptance,
  // then idles for a random gap. Payload bytes queue an expected write.
  task automatic send_byte(input logic [7:0] b, input bit payload, input int addr,
                           input int gap_max);
    int n;
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      check("ready_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    if (payload) begin
      exp_cyc.push_back(cyc + 1);
      exp_addr.push_back(addr);
      exp_data.push_back(int'(b));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, 32'(obs_cyc.size()), 32'(exp_cyc.size()));
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr_cyc"}, 32'(obs_cyc[i]), 32'(exp_cyc[i]));
      check({tag, "_wr_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check({tag, "_wr_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
    end
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
  endtask

  task automatic build_frame(input int len, input bit bad_csum);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(len >> 8));
    frame_q.push_back(8'(len));
    x = 8'd0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x = x ^ b;
    end
    frame_q.push_back(bad_csum ? ~x : x);
  endtask

  // Drives frame_q and judges the outcome from the frame rules alone.
  task automatic run_frame(input string tag, input int gap_max);
    int         len;
    logic [7:0] x;
    bit         ok;
    len = (int'(frame_q[0]) << 8) | int'(frame_q[1]);
    send_byte(frame_q[0], 1'b0, 0, gap_max);
    send_byte(frame_q[1], 1'b0, 0, (len > MemBytes) ? 0 : gap_max);
    ok = 1'b0;
    if (len <= MemBytes) begin
      x = 8'd0;
      for (int i = 0; i < len; i++) begin
        send_byte(frame_q[2 + i], 1'b1, i, gap_max);
        x = x ^ frame_q[2 + i];
      end
      send_byte(frame_q[2 + len], 1'b0, 0, 0);
      ok = (frame_q[2 + len] == x);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_error"}, 32'(error), 32'(!ok));
    check({tag, "_core_reset"}, 32'(core_reset), 32'(!ok));
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    compare_writes(tag);
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check({tag, "_rs_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_rs_done"}, 32'(done), 32'd0);
    check({tag, "_rs_error"}, 32'(error), 32'd0);
    check({tag, "_rs_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic nominal_frame(input logic [7:0] csum);
    frame_q.delete();
    frame_q.push_back(8'h00); frame_q.push_back(8'h04);
    frame_q.push_back(8'hDE); frame_q.push_back(8'hAD);
    frame_q.push_back(8'hBE); frame_q.push_back(8'hEF);
    frame_q.push_back(csum);
  endtask

  initial begin
    s_data  = 8'd0;
    s_valid = 1'b0;
    restart = 1'b0;
    reset   = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Nominal load with fixed expectations.
    nominal_frame(8'h22);
    run_frame("nominal", 0);
    pulse_restart("nominal");

    nominal_frame(8'h23);
    run_frame("bad_csum", 0);
    pulse_restart("bad_csum");

    frame_q.delete();
    frame_q.push_back(8'h01); frame_q.push_back(8'h01);
    run_frame("oversize", 0);
    pulse_restart("oversize");

    frame_q.delete();
    frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    run_frame("len0", 0);
    pulse_restart("len0");

    build_frame(256, 1'b0);
    run_frame("len256", 1);
    pulse_restart("len256");

    // Gaps on the nominal image, then hammer the stream while parked in done.
    nominal_frame(8'h22);
    run_frame("gaps", 3);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      check("done_hold_ready", 32'(s_ready), 32'd0);
      check("done_hold_done", 32'(done), 32'd1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    compare_writes("done_hold");
    pulse_restart("gaps");

    // Random frames: length, checksum validity and gaps drawn at random.
    for (int k = 0; k < 6; k++) begin
      build_frame(int'($urandom_range(0, 300)), 1'(($urandom_range(0, 3)) == 0));
      run_frame("random", 2);
      pulse_restart("random");
    end

    // Asynchronous reset after the second payload byte.
    nominal_frame(8'h22);
    send_byte(frame_q[0], 1'b0, 0, 0);
    send_byte(frame_q[1], 1'b0, 0, 0);
    send_byte(frame_q[2], 1'b1, 0, 0);
    send_byte(frame_q[3], 1'b1, 1, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
    @(posedge clk);
    #1;
    run_frame("reload", 1);
    pulse_restart("reload");
    nominal_frame(8'h22);
    run_frame("after_restart", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
